// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results directly and aligns/extends load data before the register-file write.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_result,
    input  logic            in_is_load,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            write_en,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_val,
    output logic            ld_err
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    typedef enum logic {IDLE, WAIT_LD} state_t;

    state_t          state_q, state_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic [2:0]      ld_f3_q, ld_f3_d;
    logic [1:0]      ld_off_q, ld_off_d;
    logic            write_en_q, write_en_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rd_val_q, rd_val_d;
    logic            ld_err_q, ld_err_d;
    logic            retire;

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic            ld_legal;
    logic [XLEN-1:0] ld_data;

    assign in_ready = (state_q == IDLE);

    // Load response alignment; legality depends on width and captured offset.
    always_comb begin
        ld_byte  = mem_rdata[{ld_off_q, 3'b000} +: 8];
        ld_half  = mem_rdata[{ld_off_q[1], 4'b0000} +: 16];
        ld_legal = 1'b0;
        ld_data  = '0;
        case (ld_f3_q)
            3'b000: begin ld_legal = 1'b1;          ld_data = {{24{ld_byte[7]}}, ld_byte}; end
            3'b100: begin ld_legal = 1'b1;          ld_data = {24'h0, ld_byte}; end
            3'b001: begin ld_legal = ~ld_off_q[0];  ld_data = {{16{ld_half[15]}}, ld_half}; end
            3'b101: begin ld_legal = ~ld_off_q[0];  ld_data = {16'h0, ld_half}; end
            3'b010: begin ld_legal = (ld_off_q == 2'b00); ld_data = mem_rdata; end
            default: begin ld_legal = 1'b0;         ld_data = '0; end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ld_rd_d    = ld_rd_q;
        ld_f3_d    = ld_f3_q;
        ld_off_d   = ld_off_q;
        write_en_d = 1'b0;
        rd_d       = rd_q;
        rd_val_d   = rd_val_q;
        ld_err_d   = 1'b0;
        retire     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_is_load) begin
                        ld_rd_d  = in_rd;
                        ld_f3_d  = in_funct3;
                        ld_off_d = in_addr_lo;
                        state_d  = WAIT_LD;
                    end else begin
                        write_en_d = (in_rd != 5'd0);
                        rd_d       = in_rd;
                        rd_val_d   = in_result;
                        retire     = 1'b1;
                    end
                end
            end
            WAIT_LD: begin
                if (mem_rvalid) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                    if (ld_legal) begin
                        write_en_d = (ld_rd_q != 5'd0);
                        rd_d       = ld_rd_q;
                        rd_val_d   = ld_data;
                    end else begin
                        ld_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ld_rd_q    <= '0;
            ld_f3_q    <= '0;
            ld_off_q   <= '0;
            write_en_q <= 1'b0;
            rd_q       <= '0;
            rd_val_q   <= '0;
            ld_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_rd_q    <= ld_rd_d;
            ld_f3_q    <= ld_f3_d;
            ld_off_q   <= ld_off_d;
            write_en_q <= write_en_d;
            rd_q       <= rd_d;
            rd_val_q   <= rd_val_d;
            ld_err_q   <= ld_err_d;
        end
    end

    assign write_en = write_en_q;
    assign rd       = rd_q;
    assign rd_val   = rd_val_q;
    assign ld_err   = ld_err_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q + {63'd0, retire};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) instret_q <= '0;
        else      instret_q <= instret_d;
    end

    assign instret = instret_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios followed by random ALU/load traffic against a reference model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_result = '0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [1:0]  in_addr_lo = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        write_en;
    logic [4:0]  rd;
    logic [31:0] rd_val;
    logic        ld_err;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    int tests = 0;
    int fails = 0;

    // Reference state: what the register-file port should show after each retire.
    logic [4:0]  m_rd = '0;
    logic [31:0] m_val = '0;
    logic [63:0] m_instret = '0;

    wb_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_result(in_result), .in_is_load(in_is_load),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .write_en(write_en), .rd(rd), .rd_val(rd_val), .ld_err(ld_err)
`ifdef WB_INSTRET_EN
        , .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_instret(input string tag);
`ifdef WB_INSTRET_EN
        check(tag, instret, m_instret);
`else
        tests = tests + 0;
`endif
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ld_ok(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (off % 2) == 0;
            3'd2:       return off == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
        logic [31:0] sh, v;
        sh = d >> (8 * off);
        case (f3)
            3'd0: begin v = sh % 256;   if (v >= 128)   v = v - 32'd256; end
            3'd4: v = sh % 256;
            3'd1: begin v = sh % 65536; if (v >= 32768) v = v - 32'd65536; end
            3'd5: v = sh % 65536;
            default: v = d;
        endcase
        return v;
    endfunction

    // Present a non-load for one edge; in_valid is dropped afterwards without stepping.
    task automatic alu(input logic [4:0] r, input logic [31:0] v);
        in_valid = 1'b1; in_is_load = 1'b0; in_rd = r; in_result = v;
        step();
        in_valid = 1'b0;
        m_rd = r; m_val = v; m_instret++;
        check("alu_we", write_en, r != 0);
        check("alu_rd", rd, m_rd);
        check("alu_val", rd_val, m_val);
        check("alu_err", ld_err, 0);
    endtask

    task automatic load(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] off,
                        input logic [31:0] d, input int lat);
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = r; in_funct3 = f3; in_addr_lo = off;
        in_result = $urandom;
        mem_rvalid = 1'b1; mem_rdata = $urandom; // must be ignored at acceptance
        step();
        in_valid = 1'b0; mem_rvalid = 1'b0;
        check("ld_acc_ready", in_ready, 0);
        check("ld_acc_we", write_en, 0);
        for (int i = 1; i < lat; i++) begin
            step();
            check("ld_wait_ready", in_ready, 0);
            check("ld_wait_we", write_en, 0);
        end
        mem_rvalid = 1'b1; mem_rdata = d;
        step();
        mem_rvalid = 1'b0;
        m_instret++;
        if (ld_ok(f3, off)) begin
            m_rd = r; m_val = ld_val(f3, off, d);
            check("ld_we", write_en, r != 0);
            check("ld_err", ld_err, 0);
        end else begin
            check("ld_bad_we", write_en, 0);
            check("ld_bad_err", ld_err, 1);
        end
        check("ld_rd", rd, m_rd);
        check("ld_val", rd_val, m_val);
        check("ld_ready", in_ready, 1);
    endtask

    initial begin
        #3;
        check("rst_we", write_en, 0);
        check("rst_rd", rd, 0);
        check("rst_val", rd_val, 0);
        check("rst_err", ld_err, 0);
        check("rst_ready", in_ready, 1);
        check_instret("rst_instret");
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back non-loads
        alu(5'd1, 32'hFFFF_FFFF);
        alu(5'd2, 32'hAAAA_AAAA);
        step();
        check("b2b_idle_we", write_en, 0);
        check("b2b_hold_val", rd_val, 32'hAAAA_AAAA);
        check_instret("b2b_instret");

        load(5'd5, 3'd0, 2'd3, 32'h80AA_5555, 3);
        check("lb_val_const", rd_val, 32'hFFFF_FF80);
        load(5'd6, 3'd5, 2'd2, 32'h8001_0000, 1);
        check("lhu_val_const", rd_val, 32'h0000_8001);
        load(5'd7, 3'd2, 2'd0, 32'h1234_5678, 2);
        check("lw_val_const", rd_val, 32'h1234_5678);
        load(5'd8, 3'd2, 2'd1, 32'hDEAD_BEEF, 1);
        step();
        check("err_pulse_end", ld_err, 0);
        check_instret("err_instret");

        alu(5'd0, 32'h5555_5555);
        check("rd0_val_const", rd_val, 32'h5555_5555);
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        step();
        mem_rvalid = 1'b0;
        check("idle_rvalid_we", write_en, 0);
        check("idle_rvalid_err", ld_err, 0);
        check_instret("idle_rvalid_instret");

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            logic [4:0] r;
            r = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                alu(r, $urandom);
                if ($urandom_range(0, 1) == 0) begin
                    step();
                    check("rnd_idle_we", write_en, 0);
                end
            end else begin
                load(r, 3'($urandom), 2'($urandom), $urandom, $urandom_range(1, 4));
            end
        end
        check_instret("rnd_instret");

        // Asynchronous reset while a load is pending
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd9; in_funct3 = 3'd2; in_addr_lo = 2'd0;
        step();
        in_valid = 1'b0;
        alu_dummy_wait: begin end
        #2 rst = 1'b0;
        #1;
        m_rd = '0; m_val = '0; m_instret = '0;
        check("arst_we", write_en, 0);
        check("arst_rd", rd, 0);
        check("arst_val", rd_val, 0);
        check("arst_ready", in_ready, 1);
        check_instret("arst_instret");
        @(negedge clk);
        rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        mem_rvalid = 1'b0;
        check("arst_drop_we", write_en, 0);
        check("arst_drop_val", rd_val, 0);
        alu(5'd3, 32'h0000_0042);
        check_instret("post_rst_instret");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
